wl_afifo_wptr_full: RTL and testbench

Write-side pointer and full-flag stage of the asynchronous FIFO. It synchronizes the read-domain Gray read pointer into wclk, keeps the binary and Gray write pointers, gates write requests into RAM write enables, and raises a registered full flag. Its outputs bin_wptr and w2_gray_rptr feed the almost-full flag generator directly downstream. gray_wptr goes to the read-domain synchronizer.

---
 rtl/wl_afifo_pkg.sv | 26 ++
 rtl/wl_afifo_wptr_full_if.sv | 46 ++++
 rtl/wl_sync2.sv | 27 ++
 rtl/wl_afifo_wptr_full.sv | 81 ++++++++
 tb/tb_wl_afifo_wptr_full.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wl_afifo_pkg.sv
// Shared constants and Gray-code helpers for the asynchronous FIFO pointer blocks.
// The helpers work on zero-extended 32-bit values, so callers cast to and from their own pointer width.
package wl_afifo_pkg;

    localparam int unsigned WL_AFIFO_L_DEFAULT = 3;
    localparam int unsigned WL_AFIFO_CODE_W    = 32;

    function automatic logic [WL_AFIFO_CODE_W-1:0] bin2gray(
        input logic [WL_AFIFO_CODE_W-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers the binary value.
    function automatic logic [WL_AFIFO_CODE_W-1:0] gray2bin(
        input logic [WL_AFIFO_CODE_W-1:0] gray
    );
        logic [WL_AFIFO_CODE_W-1:0] bin;
        bin = gray;
        for (int unsigned i = 1; i < WL_AFIFO_CODE_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage : wl_afifo_pkg

// File: rtl/wl_afifo_wptr_full_if.sv
// Write-side bundle between the producer/FIFO RAM and the write pointer block.
// L is the FIFO address width; pointers carry one extra wrap bit.
interface wl_afifo_wptr_full_if
    import wl_afifo_pkg::*;
#(
    parameter int unsigned L = WL_AFIFO_L_DEFAULT
);

    logic         wclr;
    logic         winc;
    logic [L:0]   gray_rptr;
    logic         wen;
    logic [L-1:0] waddr;
    logic [L:0]   bin_wptr;
    logic [L:0]   gray_wptr;
    logic [L:0]   w2_gray_rptr;
    logic         wfull;
    logic         wovf;

    modport master (
        output wclr,
        output winc,
        output gray_rptr,
        input  wen,
        input  waddr,
        input  bin_wptr,
        input  gray_wptr,
        input  w2_gray_rptr,
        input  wfull,
        input  wovf
    );

    modport slave (
        input  wclr,
        input  winc,
        input  gray_rptr,
        output wen,
        output waddr,
        output bin_wptr,
        output gray_wptr,
        output w2_gray_rptr,
        output wfull,
        output wovf
    );

endinterface : wl_afifo_wptr_full_if

// File: rtl/wl_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into clk_i.
// Only the reset clears it; functional clears belong to the pointer owners.
module wl_sync2 #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_b_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : wl_sync2

// File: rtl/wl_afifo_wptr_full.sv
// Write-domain pointer and full-flag stage of the asynchronous FIFO.
// Full is computed from the next pointer so a filling write blocks the very next request.
module wl_afifo_wptr_full
    import wl_afifo_pkg::*;
#(
    parameter int unsigned L = WL_AFIFO_L_DEFAULT
) (
    input  logic                 wclk,
    input  logic                 wrst_b,
    wl_afifo_wptr_full_if.slave  bus
);

    localparam int unsigned PW = L + 1;

    logic [PW-1:0] bin_q,   bin_d;
    logic [PW-1:0] gray_q,  gray_d;
    logic          wfull_q, wfull_d;
    logic          wovf_q,  wovf_d;

    logic [PW-1:0] w2_gray_rptr;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] full_gray;
    logic          full_val;
    logic          wen_c;

    wl_sync2 #(
        .W (PW)
    ) u_rptr_sync (
        .clk_i   (wclk),
        .rst_b_i (wrst_b),
        .d_i     (bus.gray_rptr),
        .q_o     (w2_gray_rptr)
    );

    // Full when the next write pointer equals the synced read pointer with its two top Gray bits inverted.
    always_comb begin
        wen_c     = bus.winc & ~wfull_q;
        bin_next  = bin_q + PW'(wen_c);
        gray_next = PW'(bin2gray(WL_AFIFO_CODE_W'(bin_next)));
        full_gray = {~w2_gray_rptr[L:L-1], w2_gray_rptr[L-2:0]};
        full_val  = (gray_next == full_gray);
    end

    // Next-state: clear wins over any write in the same cycle.
    always_comb begin
        bin_d   = bin_next;
        gray_d  = gray_next;
        wfull_d = full_val;
        wovf_d  = wovf_q | (bus.winc & wfull_q);
        if (bus.wclr) begin
            bin_d   = '0;
            gray_d  = '0;
            wfull_d = 1'b0;
            wovf_d  = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_b) begin
        if (!wrst_b) begin
            bin_q   <= '0;
            gray_q  <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            wfull_q <= wfull_d;
            wovf_q  <= wovf_d;
        end
    end

    assign bus.wen          = wen_c;
    assign bus.waddr        = bin_q[L-1:0];
    assign bus.bin_wptr     = bin_q;
    assign bus.gray_wptr    = gray_q;
    assign bus.w2_gray_rptr = w2_gray_rptr;
    assign bus.wfull        = wfull_q;
    assign bus.wovf         = wovf_q;

endmodule : wl_afifo_wptr_full

// File: tb/tb_wl_afifo_wptr_full.sv
// Bench for wl_afifo_wptr_full: directed scenarios plus a randomized run against an occupancy-count model.
module tb_wl_afifo_wptr_full;

    localparam int unsigned L     = 3;
    localparam int unsigned PW    = L + 1;
    localparam int          DEPTH = 8;
    localparam int          MOD   = 16;

    logic wclk = 1'b0;
    logic wrst_b;

    always #5 wclk = ~wclk;

    wl_afifo_wptr_full_if #(.L(L)) bus ();

    wl_afifo_wptr_full #(.L(L)) dut (
        .wclk   (wclk),
        .wrst_b (wrst_b),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: write count, two-stage delayed read pointer, full and overflow flags.
    int            m_wcnt;
    bit            m_full;
    bit            m_ovf;
    logic [PW-1:0] m_s1;
    logic [PW-1:0] m_s2;
    int            m_rcnt;

    function automatic logic [PW-1:0] to_gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic int from_gray(input logic [PW-1:0] g);
        int v;
        v = 0;
        for (int i = PW - 1; i >= 0; i--) begin
            v = (v << 1) | ((v & 1) ^ int'(g[i]));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_wcnt = 0;
        m_full = 0;
        m_ovf  = 0;
        m_s1   = '0;
        m_s2   = '0;
        m_rcnt = 0;
    endtask

    // Advance model with the current inputs, then the DUT by one edge; returns at edge + 1.
    task automatic tick();
        bit accepted;
        int nw;
        accepted = bus.winc && !m_full;
        if (bus.wclr) begin
            m_wcnt = 0;
            m_full = 0;
            m_ovf  = 0;
        end else begin
            nw     = (m_wcnt + int'(accepted)) % MOD;
            m_ovf  = m_ovf || (bus.winc && m_full);
            m_full = (((nw - from_gray(m_s2)) + MOD) % MOD) == DEPTH;
            m_wcnt = nw;
        end
        m_s2 = m_s1;
        m_s1 = bus.gray_rptr;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_b        = 1'b0;
        bus.winc      = 1'b0;
        bus.wclr      = 1'b0;
        bus.gray_rptr = '0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        wrst_b = 1'b1;
    endtask

    task automatic test_reset();
        wrst_b        = 1'b0;
        bus.winc      = 1'b1;
        bus.wclr      = 1'b0;
        bus.gray_rptr = '0;
        model_reset();
        #3;
        repeat (2) @(posedge wclk);
        #1;
        n_checks++;
        if (bus.bin_wptr !== 4'b0000) $display("FAIL reset_bin: got %b expected 0000", bus.bin_wptr);
        else n_pass++;
        n_checks++;
        if (bus.gray_wptr !== 4'b0000) $display("FAIL reset_gray: got %b expected 0000", bus.gray_wptr);
        else n_pass++;
        n_checks++;
        if (bus.w2_gray_rptr !== 4'b0000) $display("FAIL reset_w2: got %b expected 0000", bus.w2_gray_rptr);
        else n_pass++;
        n_checks++;
        if (bus.wfull !== 1'b0 || bus.wovf !== 1'b0)
            $display("FAIL reset_flags: got wfull=%b wovf=%b expected 0 0", bus.wfull, bus.wovf);
        else n_pass++;
        n_checks++;
        if (bus.wen !== 1'b1) $display("FAIL reset_wen: got %b expected 1", bus.wen);
        else n_pass++;
        wrst_b = 1'b1;
        tick();
        n_checks++;
        if (bus.bin_wptr !== 4'b0001 || bus.gray_wptr !== 4'b0001)
            $display("FAIL reset_first_write: got bin=%b gray=%b expected 0001 0001", bus.bin_wptr, bus.gray_wptr);
        else n_pass++;
        bus.winc = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        bus.winc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                n_checks++;
                if (bus.wfull !== 1'b0) $display("FAIL fill_not_full_at_7: got %b expected 0", bus.wfull);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (bus.bin_wptr !== 4'b1000 || bus.gray_wptr !== 4'b1100)
            $display("FAIL fill_ptr: got bin=%b gray=%b expected 1000 1100", bus.bin_wptr, bus.gray_wptr);
        else n_pass++;
        n_checks++;
        if (bus.wfull !== 1'b1 || bus.wen !== 1'b0)
            $display("FAIL fill_full: got wfull=%b wen=%b expected 1 0", bus.wfull, bus.wen);
        else n_pass++;
        n_checks++;
        if (bus.waddr !== 3'b000) $display("FAIL fill_waddr: got %b expected 000", bus.waddr);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bus.winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus.wovf !== 1'b1 || bus.bin_wptr !== 4'b1000)
                $display("FAIL ovf_cycle%0d: got wovf=%b bin=%b expected 1 1000", i, bus.wovf, bus.bin_wptr);
            else n_pass++;
        end
        bus.winc = 1'b0;
    endtask

    task automatic test_release();
        bus.winc      = 1'b0;
        bus.gray_rptr = 4'b0001;
        tick();
        n_checks++;
        if (bus.w2_gray_rptr !== 4'b0000 || bus.wfull !== 1'b1)
            $display("FAIL release_e1: got w2=%b wfull=%b expected 0000 1", bus.w2_gray_rptr, bus.wfull);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.w2_gray_rptr !== 4'b0001 || bus.wfull !== 1'b1)
            $display("FAIL release_e2: got w2=%b wfull=%b expected 0001 1", bus.w2_gray_rptr, bus.wfull);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.wfull !== 1'b0) $display("FAIL release_e3: got wfull=%b expected 0", bus.wfull);
        else n_pass++;
        bus.winc = 1'b1;
        #1;
        n_checks++;
        if (bus.wen !== 1'b1) $display("FAIL release_wen: got %b expected 1", bus.wen);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.bin_wptr !== 4'b1001 || bus.wovf !== 1'b1)
            $display("FAIL release_write: got bin=%b wovf=%b expected 1001 1", bus.bin_wptr, bus.wovf);
        else n_pass++;
        bus.winc = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.gray_rptr = to_gray(m_wcnt);
            n_checks++;
            if (bus.wfull !== 1'b0) $display("FAIL wrap_full_w%0d: got %b expected 0", i, bus.wfull);
            else n_pass++;
        end
        n_checks++;
        if (bus.bin_wptr !== 4'b0000 || bus.gray_wptr !== 4'b0000)
            $display("FAIL wrap_ptr: got bin=%b gray=%b expected 0000 0000", bus.bin_wptr, bus.gray_wptr);
        else n_pass++;
        bus.winc = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        bus.gray_rptr = 4'b1011;
        repeat (2) tick();
        bus.winc = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (bus.bin_wptr !== 4'b0101 || bus.wfull !== 1'b1)
            $display("FAIL clear_setup: got bin=%b wfull=%b expected 0101 1", bus.bin_wptr, bus.wfull);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.wovf !== 1'b1) $display("FAIL clear_setup_ovf: got %b expected 1", bus.wovf);
        else n_pass++;
        bus.wclr = 1'b1;
        tick();
        n_checks++;
        if (bus.bin_wptr !== 4'b0000 || bus.wfull !== 1'b0 || bus.wovf !== 1'b0)
            $display("FAIL clear_regs: got bin=%b wfull=%b wovf=%b expected 0000 0 0",
                     bus.bin_wptr, bus.wfull, bus.wovf);
        else n_pass++;
        n_checks++;
        if (bus.w2_gray_rptr !== 4'b1011) $display("FAIL clear_w2: got %b expected 1011", bus.w2_gray_rptr);
        else n_pass++;
        n_checks++;
        if (bus.wen !== 1'b1) $display("FAIL clear_wen_high: got %b expected 1", bus.wen);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.bin_wptr !== 4'b0000) $display("FAIL clear_drop: got %b expected 0000", bus.bin_wptr);
        else n_pass++;
        bus.wclr = 1'b0;
        bus.winc = 1'b0;
    endtask

    task automatic test_random();
        bit exp_wen;
        bit was_clr;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.winc = ($urandom_range(0, 3) != 0);
            bus.wclr = ($urandom_range(0, 63) == 0);
            #1;
            exp_wen = bus.winc && !m_full;
            n_checks++;
            if (bus.wen !== exp_wen) $display("FAIL rand_wen c%0d: got %b expected %b", cyc, bus.wen, exp_wen);
            else n_pass++;
            was_clr = bus.wclr;
            tick();
            n_checks++;
            if (bus.bin_wptr !== PW'(m_wcnt) || bus.gray_wptr !== to_gray(m_wcnt) || bus.waddr !== L'(m_wcnt))
                $display("FAIL rand_ptr c%0d: got bin=%b gray=%b addr=%b expected count %0d",
                         cyc, bus.bin_wptr, bus.gray_wptr, bus.waddr, m_wcnt);
            else n_pass++;
            n_checks++;
            if (bus.w2_gray_rptr !== m_s2) $display("FAIL rand_w2 c%0d: got %b expected %b", cyc, bus.w2_gray_rptr, m_s2);
            else n_pass++;
            n_checks++;
            if (bus.wfull !== m_full || bus.wovf !== m_ovf)
                $display("FAIL rand_flags c%0d: got wfull=%b wovf=%b expected %b %b",
                         cyc, bus.wfull, bus.wovf, m_full, m_ovf);
            else n_pass++;
            if (was_clr) m_rcnt = 0;
            else if (m_rcnt != m_wcnt && $urandom_range(0, 1) == 1) m_rcnt = (m_rcnt + 1) % MOD;
            bus.gray_rptr = to_gray(m_rcnt);
        end
        bus.winc = 1'b0;
        bus.wclr = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.gray_rptr = '0;
        #1;
        bus.winc = 1'b1;
        repeat (3) tick();
        #3;
        wrst_b = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bus.bin_wptr !== '0 || bus.gray_wptr !== '0 || bus.w2_gray_rptr !== '0 ||
            bus.wfull !== 1'b0 || bus.wovf !== 1'b0)
            $display("FAIL async_reset: got bin=%b gray=%b w2=%b wfull=%b wovf=%b expected all 0",
                     bus.bin_wptr, bus.gray_wptr, bus.w2_gray_rptr, bus.wfull, bus.wovf);
        else n_pass++;
        @(posedge wclk);
        #1;
        wrst_b = 1'b1;
        tick();
        n_checks++;
        if (bus.bin_wptr !== 4'b0001) $display("FAIL async_restart: got %b expected 0001", bus.bin_wptr);
        else n_pass++;
        bus.winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_clear();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_wl_afifo_wptr_full
